// File: rtl/seg7_scroller.sv
// Scrolling banner driver for a multiplexed common-segment 7-segment display.
// Slides a NUM_DIGITS-wide window over "UABC-ELECT" plus blank padding.
module seg7_scroller #(
    parameter int NUM_DIGITS  = 4,
    parameter int STEP_CYCLES = 1000,
    parameter int MUX_CYCLES  = 100
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  mode,
    input  logic                  restart,
    output logic [6:0]            segments,
    output logic [NUM_DIGITS-1:0] digit_sel,
    output logic                  done
);

    localparam int SEQ_LEN = 10 + NUM_DIGITS;
    localparam int POS_W   = $clog2(SEQ_LEN);
    localparam int IDX_W   = $clog2(2 * SEQ_LEN);
    localparam int STEP_W  = $clog2(STEP_CYCLES);
    localparam int MUX_W   = (MUX_CYCLES > 1) ? $clog2(MUX_CYCLES) : 1;
    localparam int DIG_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(SEQ_LEN - 1);
    localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_CYCLES - 1);
    localparam logic [MUX_W-1:0]  MUX_LAST  = MUX_W'(MUX_CYCLES - 1);
    localparam logic [DIG_W-1:0]  DIG_LAST  = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t              state, state_n;
    logic [POS_W-1:0]    pos, pos_n;
    logic [STEP_W-1:0]   step_cnt, step_n;
    logic [MUX_W-1:0]    scan_cnt, scan_n;
    logic [DIG_W-1:0]    dig, dig_n;
    logic                step_tick;

    logic [IDX_W-1:0]      win_sum;
    logic [IDX_W-1:0]      win_idx;
    logic [6:0]            glyph;
    logic [NUM_DIGITS-1:0] dig_onehot;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            pos      <= '0;
            step_cnt <= '0;
            scan_cnt <= '0;
            dig      <= '0;
        end else begin
            state    <= state_n;
            pos      <= pos_n;
            step_cnt <= step_n;
            scan_cnt <= scan_n;
            dig      <= dig_n;
        end
    end

    always_comb begin
        state_n   = state;
        pos_n     = pos;
        step_n    = step_cnt;
        scan_n    = scan_cnt;
        dig_n     = dig;
        step_tick = 1'b0;

        case (state)
            IDLE: begin
                pos_n  = '0;
                step_n = '0;
                scan_n = '0;
                dig_n  = '0;
                if (en) begin
                    state_n = RUN;
                end
            end

            RUN: begin
                // Digit scanning runs even while paused so the frozen frame stays lit.
                if (scan_cnt == MUX_LAST) begin
                    scan_n = '0;
                    dig_n  = (dig == DIG_LAST) ? '0 : dig + 1'b1;
                end else begin
                    scan_n = scan_cnt + 1'b1;
                end

                if (en) begin
                    if (step_cnt == STEP_LAST) begin
                        step_n    = '0;
                        step_tick = 1'b1;
                    end else begin
                        step_n = step_cnt + 1'b1;
                    end
                end

                if (step_tick) begin
                    if (pos != POS_LAST) begin
                        pos_n = pos + 1'b1;
                    end else if (!mode) begin
                        pos_n = '0;
                    end else begin
                        state_n = DONE;
                        step_n  = '0;
                        scan_n  = '0;
                        dig_n   = '0;
                    end
                end
            end

            DONE: begin
                if (!mode) begin
                    state_n = RUN;
                    pos_n   = '0;
                    step_n  = '0;
                    scan_n  = '0;
                    dig_n   = '0;
                end
            end

            default: begin
                state_n = IDLE;
            end
        endcase

        // Restart overrides any step or mode change landing on the same edge.
        if (restart) begin
            state_n = en ? RUN : IDLE;
            pos_n   = '0;
            step_n  = '0;
            scan_n  = '0;
            dig_n   = '0;
        end
    end

    // Window index wraps by a single conditional subtract; pos + dig < 2*SEQ_LEN.
    always_comb begin
        win_sum    = IDX_W'(pos) + IDX_W'(dig);
        win_idx    = (win_sum >= IDX_W'(SEQ_LEN)) ? win_sum - IDX_W'(SEQ_LEN) : win_sum;
        dig_onehot = NUM_DIGITS'(1) << dig;

        case (win_idx[3:0])
            4'd0:    glyph = 7'b0111110;
            4'd1:    glyph = 7'b1110111;
            4'd2:    glyph = 7'b1111100;
            4'd3:    glyph = 7'b0111001;
            4'd4:    glyph = 7'b1000000;
            4'd5:    glyph = 7'b1111001;
            4'd6:    glyph = 7'b0111000;
            4'd7:    glyph = 7'b1111001;
            4'd8:    glyph = 7'b0111001;
            4'd9:    glyph = 7'b0110001;
            default: glyph = 7'b0000000;
        endcase
        if (win_idx >= IDX_W'(10)) begin
            glyph = 7'b0000000;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            segments  <= '0;
            digit_sel <= '0;
            done      <= 1'b0;
        end else begin
            segments  <= (state == RUN) ? glyph : 7'b0000000;
            digit_sel <= (state == RUN) ? dig_onehot : '0;
            done      <= (state == DONE) && !restart;
        end
    end

endmodule

// File: tb/tb_seg7_scroller.sv
// Bench for seg7_scroller: a time-based model feeds an expected-output queue
// every cycle, and each scenario task adds its own targeted checks.
module tb_seg7_scroller;

    localparam int ND  = 4;
    localparam int SC  = 8;
    localparam int MC  = 2;
    localparam int SEQ = 14;

    localparam logic [6:0] G_U = 7'b0111110;
    localparam logic [6:0] G_C = 7'b0111001;
    localparam logic [6:0] G_T = 7'b0110001;

    logic clk     = 1'b0;
    logic rst_n   = 1'b0;
    logic en      = 1'b0;
    logic mode    = 1'b0;
    logic restart = 1'b0;

    logic [6:0]    segments;
    logic [ND-1:0] digit_sel;
    logic          done;

    int checks_total  = 0;
    int checks_passed = 0;

    logic [11:0] exp_q[$];
    logic [6:0]  glyph_tab[SEQ];

    // Model state: 0 idle, 1 run, 2 done; elapsed run clocks and enabled clocks.
    int m_state = 0;
    int m_en_t  = 0;
    int m_run_t = 0;

    seg7_scroller #(
        .NUM_DIGITS (ND),
        .STEP_CYCLES(SC),
        .MUX_CYCLES (MC)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .mode     (mode),
        .restart  (restart),
        .segments (segments),
        .digit_sel(digit_sel),
        .done     (done)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    function automatic logic [11:0] model_out(input logic rs);
        int d;
        int p;
        if (m_state == 1) begin
            d = (m_run_t / MC) % ND;
            p = (m_en_t / SC) % SEQ;
            return {1'b0, 4'(1 << d), glyph_tab[(p + d) % SEQ]};
        end
        return {(m_state == 2) && !rs, 4'b0000, 7'b0000000};
    endfunction

    task automatic cycle(input logic e, input logic m, input logic r);
        logic [11:0] exp_v;
        logic [11:0] got;
        en      = e;
        mode    = m;
        restart = r;
        exp_q.push_back(model_out(r));
        @(posedge clk);
        #1;
        if (r) begin
            m_state = e ? 1 : 0;
            m_en_t  = 0;
            m_run_t = 0;
        end else begin
            case (m_state)
                0: if (e) begin
                    m_state = 1;
                    m_en_t  = 0;
                    m_run_t = 0;
                end
                1: begin
                    m_run_t++;
                    if (e) begin
                        m_en_t++;
                        if (m && (m_en_t % SC == 0) && (((m_en_t / SC) - 1) % SEQ == SEQ - 1))
                            m_state = 2;
                    end
                end
                default: if (!m) begin
                    m_state = 1;
                    m_en_t  = 0;
                    m_run_t = 0;
                end
            endcase
        end
        exp_v = exp_q.pop_front();
        got   = {done, digit_sel, segments};
        checks_total++;
        if (got !== exp_v)
            $display("FAIL out t=%0t got done/sel/seg=%b/%b/%b exp=%b/%b/%b", $time,
                     got[11], got[10:7], got[6:0], exp_v[11], exp_v[10:7], exp_v[6:0]);
        else
            checks_passed++;
        checks_total++;
        if ($countones(digit_sel) > 1)
            $display("FAIL onehot t=%0t got sel=%b exp at most one bit", $time, digit_sel);
        else
            checks_passed++;
    endtask

    task automatic test_reset();
        #12;
        checks_total++;
        if ({done, digit_sel, segments} !== 12'h000)
            $display("FAIL reset_state got=%h exp=000", {done, digit_sel, segments});
        else
            checks_passed++;
        rst_n = 1'b1;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks_total++;
        if (digit_sel !== 4'b0001 || segments !== G_U)
            $display("FAIL first_glyph got sel=%b seg=%b exp 0001/%b", digit_sel, segments, G_U);
        else
            checks_passed++;
        while (m_en_t != 5 * SC) cycle(1, 0, 0);
        #2;
        rst_n = 1'b0;
        #1;
        checks_total++;
        if ({done, digit_sel, segments} !== 12'h000 || dut.pos !== 4'd0)
            $display("FAIL async_reset got=%h pos=%0d exp=000 pos=0",
                     {done, digit_sel, segments}, dut.pos);
        else
            checks_passed++;
        m_state = 0;
        m_en_t  = 0;
        m_run_t = 0;
        #2;
        rst_n = 1'b1;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks_total++;
        if (digit_sel !== 4'b0001 || segments !== G_U)
            $display("FAIL reset_glyph got sel=%b seg=%b exp 0001/%b", digit_sel, segments, G_U);
        else
            checks_passed++;
    endtask

    task automatic test_window();
        logic [6:0] exp_seg;
        logic [3:0] exp_sel;
        cycle(1, 0, 1);
        while (m_en_t != 8 * SC) cycle(1, 0, 0);
        for (int i = 0; i < 8; i++) begin
            cycle(1, 0, 0);
            exp_sel = 4'(1 << (i / 2));
            exp_seg = (i / 2 == 0) ? G_C : (i / 2 == 1) ? G_T : 7'b0000000;
            checks_total++;
            if (digit_sel !== exp_sel || segments !== exp_seg)
                $display("FAIL window i=%0d got sel=%b seg=%b exp %b/%b",
                         i, digit_sel, segments, exp_sel, exp_seg);
            else
                checks_passed++;
        end
    endtask

    task automatic test_loop_wrap();
        cycle(1, 0, 1);
        for (int i = 0; i < SEQ * SC; i++) begin
            cycle(1, 0, 0);
            checks_total++;
            if (done !== 1'b0)
                $display("FAIL loop_done i=%0d got=%b exp=0", i, done);
            else
                checks_passed++;
        end
        checks_total++;
        if (dut.pos !== 4'd0)
            $display("FAIL loop_pos got=%0d exp=0", dut.pos);
        else
            checks_passed++;
        cycle(1, 0, 0);
        checks_total++;
        if (digit_sel !== 4'b0001 || segments !== G_U)
            $display("FAIL loop_glyph got sel=%b seg=%b exp 0001/%b", digit_sel, segments, G_U);
        else
            checks_passed++;
    endtask

    task automatic test_one_shot();
        int n;
        cycle(1, 1, 1);
        n = 0;
        do begin
            cycle(1, 1, 0);
            n++;
        end while (done !== 1'b1 && n < 200);
        checks_total++;
        if (n !== SEQ * SC + 1)
            $display("FAIL oneshot_latency got=%0d exp=%0d", n, SEQ * SC + 1);
        else
            checks_passed++;
        for (int i = 0; i < 50; i++) begin
            cycle(1, 1, 0);
            checks_total++;
            if ({done, digit_sel, segments} !== 12'h800)
                $display("FAIL oneshot_hold i=%0d got=%h exp=800", i, {done, digit_sel, segments});
            else
                checks_passed++;
        end
        cycle(1, 1, 1);
        checks_total++;
        if (done !== 1'b0)
            $display("FAIL oneshot_restart got done=%b exp=0", done);
        else
            checks_passed++;
        cycle(1, 1, 0);
        checks_total++;
        if (digit_sel !== 4'b0001 || segments !== G_U)
            $display("FAIL oneshot_glyph got sel=%b seg=%b exp 0001/%b", digit_sel, segments, G_U);
        else
            checks_passed++;
    endtask

    task automatic test_pause();
        int changes;
        logic [3:0] prev_sel;
        cycle(1, 0, 1);
        while (m_en_t != 3 * SC + 5) cycle(1, 0, 0);
        checks_total++;
        if (dut.pos !== 4'd3 || dut.step_cnt !== 3'd5)
            $display("FAIL pause_entry got pos=%0d step=%0d exp 3/5", dut.pos, dut.step_cnt);
        else
            checks_passed++;
        changes  = 0;
        prev_sel = digit_sel;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 0, 0);
            if (digit_sel !== prev_sel) changes++;
            prev_sel = digit_sel;
        end
        checks_total++;
        if (dut.pos !== 4'd3 || dut.step_cnt !== 3'd5)
            $display("FAIL pause_hold got pos=%0d step=%0d exp 3/5", dut.pos, dut.step_cnt);
        else
            checks_passed++;
        checks_total++;
        if (changes < 9)
            $display("FAIL pause_scan got %0d sel changes exp >= 9", changes);
        else
            checks_passed++;
        cycle(1, 0, 0);
        cycle(1, 0, 0);
        checks_total++;
        if (dut.pos !== 4'd3)
            $display("FAIL pause_early got pos=%0d exp=3", dut.pos);
        else
            checks_passed++;
        cycle(1, 0, 0);
        checks_total++;
        if (dut.pos !== 4'd4 || dut.step_cnt !== 3'd0)
            $display("FAIL pause_resume got pos=%0d step=%0d exp 4/0", dut.pos, dut.step_cnt);
        else
            checks_passed++;
    endtask

    task automatic test_priority();
        cycle(1, 0, 1);
        while (m_en_t != 6 * SC + 7) cycle(1, 0, 0);
        checks_total++;
        if (dut.pos !== 4'd6 || dut.step_cnt !== 3'd7)
            $display("FAIL priority_entry got pos=%0d step=%0d exp 6/7", dut.pos, dut.step_cnt);
        else
            checks_passed++;
        cycle(1, 0, 1);
        checks_total++;
        if (dut.pos !== 4'd0 || dut.step_cnt !== 3'd0)
            $display("FAIL priority got pos=%0d step=%0d exp 0/0", dut.pos, dut.step_cnt);
        else
            checks_passed++;
        cycle(1, 0, 0);
        checks_total++;
        if (digit_sel !== 4'b0001 || segments !== G_U)
            $display("FAIL priority_glyph got sel=%b seg=%b exp 0001/%b", digit_sel, segments, G_U);
        else
            checks_passed++;
    endtask

    initial begin
        glyph_tab[0] = 7'b0111110;
        glyph_tab[1] = 7'b1110111;
        glyph_tab[2] = 7'b1111100;
        glyph_tab[3] = 7'b0111001;
        glyph_tab[4] = 7'b1000000;
        glyph_tab[5] = 7'b1111001;
        glyph_tab[6] = 7'b0111000;
        glyph_tab[7] = 7'b1111001;
        glyph_tab[8] = 7'b0111001;
        glyph_tab[9] = 7'b0110001;
        for (int i = 10; i < SEQ; i++) glyph_tab[i] = 7'b0000000;

        test_reset();
        test_window();
        test_loop_wrap();
        test_one_shot();
        test_pause();
        test_priority();

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
